byte2nib_fifo: RTL



---
 rtl/byte2nib_pkg.sv | 9 +
 rtl/byte2nib_ram.sv | 20 ++
 rtl/byte2nib_fifo.sv | 56 +++++
 3 files changed

// File: rtl/byte2nib_pkg.sv
// byte2nib_pkg: shared widths and nibble selection helper for the byte-to-nibble FIFO
package byte2nib_pkg;
  localparam int NIB_W = 4;
  localparam int BYTE_W = 8;
  // sel=0 picks the high nibble, sel=1 the low nibble
  function automatic logic [NIB_W-1:0] nib_sel(input logic [BYTE_W-1:0] b, input logic sel);
    return sel ? b[NIB_W-1:0] : b[BYTE_W-1:NIB_W];
  endfunction
endpackage

// File: rtl/byte2nib_ram.sv
// byte2nib_ram: DEPTH_BYTES x 8 storage, synchronous write port, asynchronous read port
module byte2nib_ram
  import byte2nib_pkg::*;
#(
  parameter int DEPTH_BYTES = 8,
  localparam int AW = $clog2(DEPTH_BYTES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [BYTE_W-1:0] rdata
);
  logic [BYTE_W-1:0] mem [DEPTH_BYTES];
  // storage is deliberately not reset; pointers alone define what is valid
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/byte2nib_fifo.sv
// byte2nib_fifo: byte-in, nibble-out fall-through FIFO; define BYTE2NIB_LSB_FIRST_EN to emit the low nibble first
module byte2nib_fifo
  import byte2nib_pkg::*;
#(
  parameter int DEPTH_BYTES = 8,
  localparam int AW = $clog2(DEPTH_BYTES),
  localparam int CW = AW + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_v,
  output logic              in_en,
  input  logic [BYTE_W-1:0] data_in,
  output logic              out_v,
  input  logic              out_en,
  output logic [NIB_W-1:0]  data_out,
  output logic [CW-1:0]     level
);
  localparam logic [CW-1:0] WR_MAX = CW'(2 * DEPTH_BYTES - 2);
  logic [AW-1:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [CW-1:0] count;
  logic [BYTE_W-1:0] rdata;
  logic wr, rd, sel;
  // a free byte slot needs two free nibbles, so one pending odd nibble blocks writes
  assign in_en = count <= WR_MAX;
  assign out_v = count != '0;
  assign wr = in_v & in_en;
  assign rd = out_v & out_en;
  assign level = count;
`ifdef BYTE2NIB_LSB_FIRST_EN
  assign sel = ~rd_ptr[0];
`else
  assign sel = rd_ptr[0];
`endif
  assign data_out = out_v ? nib_sel(rdata, sel) : '0;
  byte2nib_ram #(.DEPTH_BYTES(DEPTH_BYTES)) u_ram (
    .clk  (clk),
    .we   (wr),
    .waddr(wr_ptr),
    .wdata(data_in),
    .raddr(rd_ptr[AW:1]),
    .rdata(rdata)
  );
  // pointers wrap naturally at their widths; count adds two per byte in, subtracts one per nibble out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{(CW-2){1'b0}}, wr, 1'b0} - {{(CW-1){1'b0}}, rd};
    end
endmodule
